// File: rtl/cop0_vec.sv
// Coprocessor-0 exception/interrupt controller with vectored IRQ handlers.
// Optional macro COP0_VEC_IRQ_SYNC_EN adds a 2-flop synchronizer on i_irq.
module cop0_vec #(
  parameter int          N_IRQ         = 4,
  parameter logic [31:0] BASE_VECTOR   = 32'h5,
  parameter logic [31:0] VECTOR_STRIDE = 32'h10,
  parameter logic [4:0]  STATUS_ADDR   = 5'd12,
  parameter logic [4:0]  CAUSE_ADDR    = 5'd13,
  parameter logic [4:0]  EPC_ADDR      = 5'd14,
  parameter logic [4:0]  PENDING_ADDR  = 5'd15
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_IRQ-1:0] i_irq,
  input  logic             i_arithmetic_overflow,
  input  logic             i_unknown_command,
  input  logic             i_unknown_func,
  input  logic [31:0]      i_pc_to_epc_from_execute,
  input  logic [31:0]      i_pc_to_epc_from_decode,
  input  logic [31:0]      i_pc_to_epc_from_fetch,
  input  logic             i_mtc0,
  input  logic [4:0]       i_address,
  input  logic [31:0]      i_data,
  input  logic             i_eret,
  output logic             o_exeption,
  output logic [31:0]      o_handler_address,
  output logic [31:0]      o_epc_to_pc,
  output logic [31:0]      o_data
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [31:0]      status_q, status_d;
  logic [31:0]      cause_q, cause_d;
  logic [31:0]      epc_q, epc_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] irq_in, irq_cand, w1c_mask, take_mask;
  logic [2:0]       irq_id;
  logic             ovf, unk, irq_any;
  logic             take, take_ovf, take_unk, take_irq;
  logic             wr_status, wr_cause, wr_epc, wr_pending;

`ifdef COP0_VEC_IRQ_SYNC_EN
  logic [N_IRQ-1:0] irq_s1_q, irq_s1_d, irq_s2_q, irq_s2_d;

  always_comb begin
    irq_s1_d = i_irq;
    irq_s2_d = irq_s1_q;
    irq_in   = irq_s2_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      irq_s1_q <= '0;
      irq_s2_q <= '0;
    end else begin
      irq_s1_q <= irq_s1_d;
      irq_s2_q <= irq_s2_d;
    end
  end
`else
  always_comb irq_in = i_irq;
`endif

  always_comb begin
    ovf      = i_arithmetic_overflow & status_q[8];
    unk      = (i_unknown_command | i_unknown_func) & status_q[9];
    irq_cand = (pending_q | irq_in) & status_q[16 +: N_IRQ];
    irq_any  = |irq_cand;
    irq_id   = 3'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (irq_cand[i]) irq_id = 3'(i);
    end
    // Gating with i_rst_n keeps the strobe quiet while reset is held.
    take     = i_rst_n & (ovf | unk | irq_any) & status_q[0] & (state_q == IDLE);
    take_ovf = take & ovf;
    take_unk = take & ~ovf & unk;
    take_irq = take & ~ovf & ~unk;
    for (int i = 0; i < N_IRQ; i++) begin
      take_mask[i] = take_irq && (irq_id == 3'(i));
    end
  end

  always_comb begin
    wr_status  = i_mtc0 && (i_address == STATUS_ADDR);
    wr_cause   = i_mtc0 && (i_address == CAUSE_ADDR);
    wr_epc     = i_mtc0 && (i_address == EPC_ADDR);
    wr_pending = i_mtc0 && (i_address == PENDING_ADDR);
    w1c_mask   = wr_pending ? i_data[N_IRQ-1:0] : '0;

    status_d  = wr_status ? i_data : status_q;
    // A new request beats a software clear; taking the IRQ clears it regardless.
    pending_d = ((pending_q & ~w1c_mask) | irq_in) & ~take_mask;

    cause_d = cause_q;
    if (take)          cause_d = {16'b0, 1'b0, (take_irq ? irq_id : 3'd0), 9'b0,
                                  take_ovf, take_unk, take_irq};
    else if (wr_cause) cause_d = i_data;

    epc_d = epc_q;
    if (take_ovf)      epc_d = i_pc_to_epc_from_execute;
    else if (take_unk) epc_d = i_pc_to_epc_from_decode;
    else if (take_irq) epc_d = i_pc_to_epc_from_fetch;
    else if (wr_epc)   epc_d = i_data;

    state_d = state_q;
    case (state_q)
      IDLE:    if (take)   state_d = BUSY;
      BUSY:    if (i_eret) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      status_q  <= 32'h0000_0101;
      cause_q   <= '0;
      epc_q     <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    o_exeption        = take;
    o_handler_address = take_irq ? BASE_VECTOR + ({29'd0, irq_id} + 32'd1) * VECTOR_STRIDE
                                 : BASE_VECTOR;
    o_epc_to_pc       = epc_q;
    o_data            = 32'd0;
    if (i_address == STATUS_ADDR)       o_data = status_q;
    else if (i_address == CAUSE_ADDR)   o_data = cause_q;
    else if (i_address == EPC_ADDR)     o_data = epc_q;
    else if (i_address == PENDING_ADDR) o_data = {{(32-N_IRQ){1'b0}}, pending_q};
  end

endmodule

// File: tb/tb_cop0_vec.sv
// Self-checking bench for cop0_vec: directed scenarios plus random traffic
// against a behavioural model of the exception/interrupt rules.
module tb_cop0_vec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  irq;
  logic        ovf, ucmd, ufunc;
  logic [31:0] pce, pcd, pcf;
  logic        mtc0;
  logic [4:0]  addr;
  logic [31:0] data;
  logic        eret;
  logic        exc;
  logic [31:0] hnd, epc_out, rdata;

  int n_assert = 0;
  int n_fail   = 0;

  cop0_vec dut (
    .i_clk                    (clk),
    .i_rst_n                  (rst_n),
    .i_irq                    (irq),
    .i_arithmetic_overflow    (ovf),
    .i_unknown_command        (ucmd),
    .i_unknown_func           (ufunc),
    .i_pc_to_epc_from_execute (pce),
    .i_pc_to_epc_from_decode  (pcd),
    .i_pc_to_epc_from_fetch   (pcf),
    .i_mtc0                   (mtc0),
    .i_address                (addr),
    .i_data                   (data),
    .i_eret                   (eret),
    .o_exeption               (exc),
    .o_handler_address        (hnd),
    .o_epc_to_pc              (epc_out),
    .o_data                   (rdata)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [31:0] m_status, m_cause, m_epc;
  logic [3:0]  m_pend, m_sync1, m_sync2, m_irq_eff;
  bit          m_busy;
  int          m_kind;  // 0 none, 1 overflow, 2 unknown, 3 irq
  int          m_id;
  bit          e_exc;
  logic [31:0] e_hnd, e_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_status = 32'h0000_0101;
    m_cause  = 0;
    m_epc    = 0;
    m_pend   = 0;
    m_sync1  = 0;
    m_sync2  = 0;
    m_busy   = 0;
  endtask

  task automatic model_eval();
`ifdef COP0_VEC_IRQ_SYNC_EN
    m_irq_eff = m_sync2;
`else
    m_irq_eff = irq;
`endif
    m_kind = 0;
    m_id   = 0;
    if (!m_busy && m_status[0]) begin
      if (ovf && m_status[8])                m_kind = 1;
      else if ((ucmd || ufunc) && m_status[9]) m_kind = 2;
      else begin
        for (int i = 0; i < 4; i++) begin
          if (m_kind == 0 && (m_pend[i] || m_irq_eff[i]) && m_status[16+i]) begin
            m_kind = 3;
            m_id   = i;
          end
        end
      end
    end
    e_exc = (m_kind != 0);
    e_hnd = (m_kind == 3) ? 32'(5 + (m_id + 1) * 16) : 32'h5;
    case (addr)
      5'd12:   e_rd = m_status;
      5'd13:   e_rd = m_cause;
      5'd14:   e_rd = m_epc;
      5'd15:   e_rd = {28'd0, m_pend};
      default: e_rd = 0;
    endcase
  endtask

  task automatic model_commit();
    if (mtc0 && addr == 5'd12) m_status = data;
    for (int i = 0; i < 4; i++) begin
      if (m_irq_eff[i])                          m_pend[i] = 1'b1;
      else if (mtc0 && addr == 5'd15 && data[i]) m_pend[i] = 1'b0;
      if (m_kind == 3 && m_id == i)              m_pend[i] = 1'b0;
    end
    case (m_kind)
      1: begin m_cause = 32'h4; m_epc = pce; end
      2: begin m_cause = 32'h2; m_epc = pcd; end
      3: begin m_cause = 32'((m_id << 12) | 1); m_epc = pcf; end
      default: begin
        if (mtc0 && addr == 5'd13) m_cause = data;
        if (mtc0 && addr == 5'd14) m_epc   = data;
      end
    endcase
    if (e_exc)     m_busy = 1;
    else if (eret) m_busy = 0;
    m_sync2 = m_sync1;
    m_sync1 = irq;
  endtask

  task automatic idle_inputs();
    irq = 0; ovf = 0; ucmd = 0; ufunc = 0;
    pce = 0; pcd = 0; pcf = 0;
    mtc0 = 0; addr = 0; data = 0; eret = 0;
  endtask

  // Inputs are set after a rising edge; outputs sampled after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
    model_eval();
    check("exception", exc, e_exc);
    check("handler", hnd, e_hnd);
    check("readback", rdata, e_rd);
    check("epc_out", epc_out, m_epc);
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic peek(input logic [4:0] a, input logic [31:0] exp, input string tag);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    idle_inputs();
    mtc0 = 1; addr = a; data = d;
    step();
  endtask

  task automatic do_eret();
    idle_inputs();
    eret = 1;
    step();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // Reset values
    peek(5'd12, 32'h101, "rst_status");
    peek(5'd13, 32'h0,   "rst_cause");
    peek(5'd14, 32'h0,   "rst_epc");
    peek(5'd15, 32'h0,   "rst_pending");
    step();

    // IRQ1 vectored
    write_reg(5'd12, 32'h0002_0001);
    idle_inputs();
    irq = 4'b0010; pcf = 32'h40;
`ifndef COP0_VEC_IRQ_SYNC_EN
    #1;
    check("irq1_exc", exc, 32'd1);
    check("irq1_hnd", hnd, 32'h25);
`endif
    step();
`ifndef COP0_VEC_IRQ_SYNC_EN
    idle_inputs();
    peek(5'd14, 32'h40,   "irq1_epc");
    peek(5'd13, 32'h1001, "irq1_cause");
    peek(5'd15, 32'h0,    "irq1_pending");
    step();
`endif
    do_eret();
    repeat (3) begin idle_inputs(); step(); end
    do_eret();

    // Priority: overflow over unknown over irq0
    write_reg(5'd12, 32'h000F_0301);
    idle_inputs();
    ovf = 1; ucmd = 1; irq = 4'b0001;
    pce = 32'h80; pcd = 32'h99; pcf = 32'h77;
    #1;
    check("prio_exc", exc, 32'd1);
    check("prio_hnd", hnd, 32'h5);
    step();
    idle_inputs();
`ifndef COP0_VEC_IRQ_SYNC_EN
    peek(5'd14, 32'h80, "prio_epc");
    peek(5'd13, 32'h4,  "prio_cause");
    peek(5'd15, 32'h1,  "prio_pending");
`endif
    step();
    do_eret();
    idle_inputs();
    pcf = 32'h123;
`ifndef COP0_VEC_IRQ_SYNC_EN
    #1;
    check("irq0_after_eret_exc", exc, 32'd1);
    check("irq0_after_eret_hnd", hnd, 32'h15);
`endif
    step();

    // Masked IRQ3 caught while busy, taken after eret
    write_reg(5'd12, 32'h0007_0301);
    idle_inputs();
    irq = 4'b1000;
    step();
    idle_inputs();
    peek(5'd15, 32'h8, "busy_pend3");
    mtc0 = 1; addr = 5'd12; data = 32'h000F_0301; eret = 1;
    step();
    idle_inputs();
    #1;
    check("irq3_exc", exc, 32'd1);
    check("irq3_hnd", hnd, 32'h45);
    step();
    idle_inputs();
    peek(5'd15, 32'h0, "irq3_pend_clr");
    step();
    do_eret();

    // W1C versus simultaneous set
    write_reg(5'd12, 32'h0000_0101);
    idle_inputs();
    irq = 4'b0100;
    step();
    idle_inputs();
    irq = 4'b0100; mtc0 = 1; addr = 5'd15; data = 32'h4;
    step();
    idle_inputs();
    peek(5'd15, 32'h4, "w1c_set_wins");
    step();
    write_reg(5'd15, 32'h4);
    idle_inputs();
    peek(5'd15, 32'h0, "w1c_clear");
    step();

    // IRQ latency
    write_reg(5'd12, 32'h0001_0001);
    idle_inputs();
    irq = 4'b0001;
`ifndef COP0_VEC_IRQ_SYNC_EN
    #1;
    check("lat_cycle0", exc, 32'd1);
    step();
`else
    #1;
    check("lat_cycle0", exc, 32'd0);
    step();
    idle_inputs(); irq = 4'b0001;
    #1;
    check("lat_cycle1", exc, 32'd0);
    step();
    idle_inputs(); irq = 4'b0001;
    #1;
    check("lat_cycle2", exc, 32'd1);
    step();
`endif
    repeat (3) do_eret();
    write_reg(5'd15, 32'hF);

    // Reset while busy
    write_reg(5'd12, 32'h0000_0101);
    idle_inputs();
    ovf = 1; pce = 32'h55;
    step();
    idle_inputs();
    ovf = 1;
    #1 rst_n = 1'b0;
    #1;
    check("in_reset_exc", exc, 32'd0);
    peek(5'd12, 32'h101, "in_reset_status");
    peek(5'd14, 32'h0,   "in_reset_epc");
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    idle_inputs();
    ovf = 1; pce = 32'h66;
    #1;
    check("post_reset_exc", exc, 32'd1);
    step();
    do_eret();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      idle_inputs();
      irq   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      ovf   = ($urandom_range(0, 9) == 0);
      ucmd  = ($urandom_range(0, 11) == 0);
      ufunc = ($urandom_range(0, 11) == 0);
      pce   = $urandom; pcd = $urandom; pcf = $urandom;
      eret  = ($urandom_range(0, 4) == 0);
      addr  = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
      if ($urandom_range(0, 7) == 0) begin
        mtc0 = 1;
        data = $urandom;
        if (addr == 5'd12 && $urandom_range(0, 3) != 0) data = data | 32'h301;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
